// File: rtl/fft_adapt_pkg.sv
// Shared definitions for the FFT stream adapter.
//   ERR_MISMATCH / ERR_FLUSH : bit positions inside the 2-bit out_error field
//   ERR_CODE_*               : complete out_error codes
//   beat_ctl_t               : per-beat framing/status bits carried through the skid buffer
//   ch_width()               : channel tag width, never below 1 bit
package fft_adapt_pkg;

  localparam int ERR_MISMATCH = 0;
  localparam int ERR_FLUSH    = 1;

  localparam logic [1:0] ERR_CODE_NONE     = 2'b00;
  localparam logic [1:0] ERR_CODE_MISMATCH = 2'b01;
  localparam logic [1:0] ERR_CODE_FLUSH    = 2'b10;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [1:0] error;
  } beat_ctl_t;

  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fft_skid_buf.sv
// Two-entry registered skid buffer (FIFO of depth 2).
//   i_clk, i_rst_n : clock, async active-low reset
//   i_push, i_data : write one payload word (caller guarantees !o_full)
//   o_full         : registered, both entries occupied
//   o_valid, o_data, i_ready : read side, word leaves on o_valid & i_ready
// The full flag depends only on stored state, so the upstream ready has no
// combinational path from the downstream ready.
module fft_skid_buf #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  output logic         o_full,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_cnt;
  logic         w_pop;

  assign o_valid = (r_cnt != 2'd0);
  assign o_full  = r_cnt[1];
  assign o_data  = r_mem[r_rd_ptr];
  assign w_pop   = o_valid & i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/fft_stream_adapter.sv
// Avalon-ST packetiser in front of the FFT sink: cuts a tagged complex sample
// stream into 2**POINTS_LOG2-point frames, round-robins frames over CHANNELS,
// drops samples whose tag does not match the active channel (flagged on eop),
// and closes a frame early on in_flush with a zero-data eop beat.
// Optional build macro: FFT_ADAPT_ERRCNT_EN adds err_count (saturating count
// of eop beats transferred with a non-zero error code).
// Ports:
//   clk_clk, reset_reset_n         : clock, async active-low reset
//   in_valid/in_ready/in_data/in_channel/in_flush : sample input
//   out_valid/out_ready/out_data/out_channel/out_startofpacket/
//   out_endofpacket/out_error      : FFT sink side
module fft_stream_adapter
  import fft_adapt_pkg::*;
#(
  parameter int DATA_W      = 22,
  parameter int POINTS_LOG2 = 10,
  parameter int CHANNELS    = 1,
  localparam int CH_W       = ch_width(CHANNELS)
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]     in_channel,
  input  logic                in_flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_data,
  output logic [CH_W-1:0]     out_channel,
  output logic                out_startofpacket,
  output logic                out_endofpacket,
  output logic [1:0]          out_error
`ifdef FFT_ADAPT_ERRCNT_EN
  ,
  output logic [15:0]         err_count
`endif
);

  typedef struct packed {
    logic [2*DATA_W-1:0] data;
    logic [CH_W-1:0]     channel;
    beat_ctl_t           ctl;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  logic [POINTS_LOG2-1:0] r_cnt;
  logic [CH_W-1:0]        r_ach;
  logic                   r_mm;
  logic                   r_pf;
  logic                   r_rdy_en;

  logic                   w_full;
  logic                   w_tag_ok;
  logic                   w_accept;
  logic                   w_take;
  logic                   w_flush_emit;
  logic                   w_push;
  logic                   w_last;
  logic [CH_W-1:0]        w_ach_next;
  beat_t                  w_beat;
  logic [BEAT_W-1:0]      w_sb_data;
  beat_t                  w_out;

  // r_rdy_en keeps in_ready low while in reset and releases it one edge later.
  assign w_tag_ok     = (CHANNELS == 1) || (in_channel == r_ach);
  assign in_ready     = r_rdy_en & ~w_full & ~r_pf & ~in_flush;
  assign w_accept     = in_valid & in_ready;
  assign w_take       = w_accept & w_tag_ok;
  assign w_flush_emit = r_pf & ~w_full;
  assign w_push       = w_take | w_flush_emit;
  assign w_last       = &r_cnt;
  assign w_ach_next   = (r_ach == CH_W'(CHANNELS - 1)) ? '0 : r_ach + 1'b1;

  always_comb begin
    w_beat         = '0;
    w_beat.channel = r_ach;
    if (w_flush_emit) begin
      w_beat.ctl.eop                 = 1'b1;
      w_beat.ctl.error[ERR_FLUSH]    = 1'b1;
      w_beat.ctl.error[ERR_MISMATCH] = r_mm;
    end else begin
      w_beat.data                    = in_data;
      w_beat.ctl.sop                 = (r_cnt == '0);
      w_beat.ctl.eop                 = w_last;
      w_beat.ctl.error[ERR_MISMATCH] = w_last & r_mm;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_cnt    <= '0;
      r_ach    <= '0;
      r_mm     <= 1'b0;
      r_pf     <= 1'b0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_flush_emit) begin
        r_cnt <= '0;
        r_ach <= '0;
        r_mm  <= 1'b0;
        r_pf  <= 1'b0;
      end else if (in_flush && !r_pf) begin
        // Empty frame: nothing to close, just realign to channel 0.
        if (r_cnt != '0) begin
          r_pf <= 1'b1;
        end else begin
          r_ach <= '0;
          r_mm  <= 1'b0;
        end
      end else if (w_take) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_ach <= w_ach_next;
          r_mm  <= 1'b0;
        end
      end else if (w_accept) begin
        r_mm <= 1'b1;
      end
    end
  end

  fft_skid_buf #(.W(BEAT_W)) u_skid (
    .i_clk   (clk_clk),
    .i_rst_n (reset_reset_n),
    .i_push  (w_push),
    .i_data  (w_beat),
    .o_full  (w_full),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_sb_data)
  );

  assign w_out             = beat_t'(w_sb_data);
  assign out_data          = w_out.data;
  assign out_channel       = w_out.channel;
  assign out_startofpacket = w_out.ctl.sop;
  assign out_endofpacket   = w_out.ctl.eop;
  // A drained entry may still hold an eop beat's error; keep it off the bus.
  assign out_error         = out_valid ? w_out.ctl.error : ERR_CODE_NONE;

`ifdef FFT_ADAPT_ERRCNT_EN
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      err_count <= 16'd0;
    end else if (out_valid && out_ready && out_endofpacket &&
                 (out_error != ERR_CODE_NONE) && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_stream_adapter.sv
module tb_fft_stream_adapter;

  localparam int DW = 22;
  localparam int PL = 3;
  localparam int P  = 1 << PL;
  localparam int CH = 2;

  logic          clk_clk;
  logic          reset_reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [2*DW-1:0] in_data;
  logic [0:0]    in_channel;
  logic          in_flush;
  logic          out_valid;
  logic          out_ready;
  logic [2*DW-1:0] out_data;
  logic [0:0]    out_channel;
  logic          out_startofpacket;
  logic          out_endofpacket;
  logic [1:0]    out_error;
`ifdef FFT_ADAPT_ERRCNT_EN
  logic [15:0]   err_count;
`endif

  fft_stream_adapter #(.DATA_W(DW), .POINTS_LOG2(PL), .CHANNELS(CH)) dut (
    .clk_clk           (clk_clk),
    .reset_reset_n     (reset_reset_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_channel        (in_channel),
    .in_flush          (in_flush),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_channel       (out_channel),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_error         (out_error)
`ifdef FFT_ADAPT_ERRCNT_EN
    ,
    .err_count         (err_count)
`endif
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  typedef struct {
    logic [2*DW-1:0] data;
    int              ch;
    logic            sop;
    logic            eop;
    logic [1:0]      err;
  } exp_t;

  exp_t q[$];
  int   m_pos;    // samples kept in the current frame
  int   m_ch;     // channel owning the current frame
  bit   m_bad;    // a foreign-tag sample was dropped during this frame
  bit   m_flush;  // flush requested, closing beat not yet queued
  int   m_errs;
  int   checks;
  int   failures;
  logic tog;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*DW-1:0] rnd_data();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[2*DW-1:0];
  endfunction

  task automatic model_clear();
    q.delete();
    m_pos = 0; m_ch = 0; m_bad = 0; m_flush = 0; m_errs = 0;
  endtask

  // One clock: drive, compare against the model, advance the model, clock.
  task automatic cycle(input logic v, input logic [2*DW-1:0] d, input int ch,
                       input logic fl, input logic ordy, output logic acc);
    bit   space;
    logic exp_rdy;
    exp_t b;
    in_valid = v; in_data = d; in_channel = ch[0]; in_flush = fl; out_ready = ordy;
    #1;
    space   = (q.size() < 2);
    exp_rdy = space && !m_flush && !fl;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0].data);
      chk("out_channel", out_channel, q[0].ch);
      chk("out_sop", out_startofpacket, q[0].sop);
      chk("out_eop", out_endofpacket, q[0].eop);
      chk("out_error", out_error, q[0].err);
    end else begin
      chk("out_error_idle", out_error, 2'b00);
    end
    if (q.size() != 0 && ordy) begin
      if (q[0].eop && q[0].err != 2'b00) m_errs++;
      void'(q.pop_front());
    end
    acc = v && exp_rdy;
    if (m_flush && space) begin
      b = '{data: '0, ch: m_ch, sop: 1'b0, eop: 1'b1, err: {1'b1, m_bad}};
      q.push_back(b);
      m_pos = 0; m_ch = 0; m_bad = 0; m_flush = 0;
    end else if (fl && !m_flush) begin
      if (m_pos != 0) m_flush = 1;
      else begin m_ch = 0; m_bad = 0; end
    end else if (acc) begin
      if (ch == m_ch) begin
        b = '{data: d, ch: m_ch, sop: (m_pos == 0), eop: (m_pos == P - 1),
              err: {1'b0, (m_pos == P - 1) ? m_bad : 1'b0}};
        q.push_back(b);
        m_pos++;
        if (m_pos == P) begin
          m_pos = 0; m_ch = (m_ch + 1) % CH; m_bad = 0;
        end
      end else begin
        m_bad = 1;
      end
    end
    @(posedge clk_clk); #1;
  endtask

  function automatic logic pick_rdy(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) begin tog = ~tog; return tog; end
    return logic'($urandom_range(1, 0));
  endfunction

  task automatic send(input int ch, input int mode);
    logic acc;
    int   n;
    acc = 0; n = 0;
    while (!acc && n < 40) begin
      cycle(1'b1, rnd_data(), ch, 1'b0, pick_rdy(mode), acc);
      n++;
    end
    if (!acc) begin
      checks++; failures++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted ch=%0d", ch);
    end
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      cycle(1'b0, '0, 0, 1'b0, 1'b1, acc);
      n++;
    end
    cycle(1'b0, '0, 0, 1'b0, 1'b1, acc);
  endtask

  task automatic do_reset();
    in_valid = 0; in_flush = 0; out_ready = 0; in_data = '0; in_channel = '0;
    reset_reset_n = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_channel", out_channel, '0);
    chk("rst_sop", out_startofpacket, 1'b0);
    chk("rst_eop", out_endofpacket, 1'b0);
    chk("rst_out_error", out_error, 2'b00);
    model_clear();
    @(posedge clk_clk); @(posedge clk_clk);
    #3 reset_reset_n = 1'b1;
    @(posedge clk_clk); #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    logic acc;
    checks = 0; failures = 0; tog = 0;
    @(posedge clk_clk); #1;
    do_reset();

    // Two full frames, channel 0 then 1, out_ready held high.
    for (int i = 0; i < 2 * P; i++) send(i / P, 0);
    drain();

    // Foreign tag on sample 3 of frame 0.
    for (int i = 0; i < P + 1; i++) send((i == 3) ? 1 : 0, 0);
    for (int i = 0; i < P; i++) send(1, 0);
    drain();

    // Flush after 5 samples, then a clean frame on channel 0.
    for (int i = 0; i < 5; i++) send(0, 0);
    cycle(1'b0, '0, 0, 1'b1, 1'b1, acc);
    drain();
    for (int i = 0; i < P; i++) send(0, 0);
    drain();

    // Flush coinciding with a valid sample at a frame boundary (channel 1 due).
    cycle(1'b1, rnd_data(), 1, 1'b1, 1'b1, acc);
    chk("flush_blocks_sample", acc, 1'b0);
    send(0, 0);
    for (int i = 1; i < P; i++) send(0, 0);
    drain();

    // Backpressure: out_ready alternating every cycle.
    for (int i = 0; i < 32; i++) send((i / P) % CH, 1);
    drain();

    // Randomised traffic: stray tags, flushes, random backpressure.
    for (int i = 0; i < 400; i++) begin
      cycle(logic'($urandom_range(3, 0) != 0), rnd_data(),
            ($urandom_range(7, 0) == 0) ? (1 - m_ch) : m_ch,
            logic'($urandom_range(39, 0) == 0), logic'($urandom_range(1, 0)), acc);
    end
    drain();

`ifdef FFT_ADAPT_ERRCNT_EN
    chk("err_count", err_count, m_errs);
`endif

    // Reset with beats stalled in the buffer mid-frame.
    for (int i = 0; i < 3; i++) cycle(1'b1, rnd_data(), m_ch, 1'b0, 1'b0, acc);
    chk("stalled_valid", out_valid, 1'b1);
    do_reset();
    for (int i = 0; i < P; i++) send(0, 2);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
